// File: rtl/point_on_curve_check.sv
// point_on_curve_check: checks that an affine point (x, y) satisfies
// y^2 == x^3 + B (mod P), or is the (0,0) identity encoding.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   in_valid / in_ready   input handshake for x_in, y_in (WIDTH bits each)
//   out_valid / out_ready result handshake; outputs held until accepted
//   on_curve              point is on the curve or is the identity
//   is_infinity           input was (0,0)
//   out_of_range          x or y >= P (only with POC_RANGE_CHECK_EN)
//
// Optional: define POC_RANGE_CHECK_EN to reject unreduced coordinates.
// A single bit-serial MSB-first modular multiplier computes y*y, x*x
// and xx*x in turn, WIDTH cycles each.
module point_on_curve_check #(
   parameter int WIDTH = 256,
   parameter logic [WIDTH-1:0] P =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
   parameter logic [WIDTH-1:0] B = 256'd7
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef POC_RANGE_CHECK_EN
   output logic             out_of_range,
`endif
   output logic             on_curve,
   output logic             is_infinity
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLASSIFY,
      MUL_YY,
      MUL_XX,
      MUL_XXX,
      FINAL,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] x_r, y_r;
   logic [WIDTH-1:0] acc, yy, xx;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] mul_a, mul_b;
   logic             mul_bit;
   logic [WIDTH:0]   dbl, dbl_red, add, add_red;
   logic [WIDTH-1:0] step;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] rhs;
   logic             is_zero, bad_range, last;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign is_zero   = (x_r == '0) && (y_r == '0);
   assign last      = (cnt == '0);

`ifdef POC_RANGE_CHECK_EN
   assign bad_range = (x_r >= P) || (y_r >= P);
`else
   assign bad_range = 1'b0;
`endif

   // Operand selection: multiplicand a, multiplier bits from b.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      unique case (state)
         MUL_YY: begin
            mul_a = y_r;
            mul_b = y_r;
         end
         MUL_XX: begin
            mul_a = x_r;
            mul_b = x_r;
         end
         MUL_XXX: begin
            mul_a = xx;
            mul_b = x_r;
         end
         default: ;
      endcase
   end

   // One add-shift step; each partial stays below P so one
   // conditional subtract per double/add suffices.
   always_comb begin
      mul_bit = mul_b[cnt];
      dbl     = {acc, 1'b0};
      dbl_red = (dbl >= {1'b0, P}) ? dbl - {1'b0, P} : dbl;
      add     = dbl_red + {1'b0, mul_a};
      add_red = (add >= {1'b0, P}) ? add - {1'b0, P} : add;
      step    = mul_bit ? add_red[WIDTH-1:0] : dbl_red[WIDTH-1:0];
      sum     = {1'b0, xx} + {1'b0, B};
      rhs     = (sum >= {1'b0, P}) ? WIDTH'(sum - {1'b0, P})
                                   : sum[WIDTH-1:0];
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (in_valid) state_nxt = CLASSIFY;
         CLASSIFY: begin
            if (bad_range || is_zero) state_nxt = DONE;
            else                      state_nxt = MUL_YY;
         end
         MUL_YY:   if (last) state_nxt = MUL_XX;
         MUL_XX:   if (last) state_nxt = MUL_XXX;
         MUL_XXX:  if (last) state_nxt = FINAL;
         FINAL:    state_nxt = DONE;
         DONE:     if (out_ready) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_r          <= '0;
         y_r          <= '0;
         acc          <= '0;
         yy           <= '0;
         xx           <= '0;
         cnt          <= '0;
         on_curve     <= 1'b0;
         is_infinity  <= 1'b0;
`ifdef POC_RANGE_CHECK_EN
         out_of_range <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  x_r          <= x_in;
                  y_r          <= y_in;
                  acc          <= '0;
                  cnt          <= CNT_TOP;
                  on_curve     <= 1'b0;
                  is_infinity  <= 1'b0;
`ifdef POC_RANGE_CHECK_EN
                  out_of_range <= 1'b0;
`endif
               end
            end
            CLASSIFY: begin
               if (bad_range) begin
`ifdef POC_RANGE_CHECK_EN
                  out_of_range <= 1'b1;
`endif
                  on_curve     <= 1'b0;
                  is_infinity  <= 1'b0;
               end else if (is_zero) begin
                  on_curve    <= 1'b1;
                  is_infinity <= 1'b1;
               end
            end
            MUL_YY, MUL_XX, MUL_XXX: begin
               if (last) begin
                  acc <= '0;
                  cnt <= CNT_TOP;
                  if (state == MUL_YY) yy <= step;
                  else                 xx <= step;
               end else begin
                  acc <= step;
                  cnt <= cnt - 1'b1;
               end
            end
            FINAL: begin
               on_curve    <= (yy == rhs);
               is_infinity <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_point_on_curve_check.sv
// tb_point_on_curve_check: directed checks of point_on_curve_check
// using secp256k1 generator-derived vectors.
module tb_point_on_curve_check;

   localparam logic [255:0] P =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
   localparam logic [255:0] GX =
      256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
   localparam logic [255:0] GY =
      256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
   localparam logic [255:0] GY1 = GY + 256'd1;
   localparam logic [255:0] GYN = P - GY;
   localparam int LAT_FULL = 771;
   localparam int LAT_FAST = 2;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [255:0] x_in = '0;
   logic [255:0] y_in = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         on_curve;
   logic         is_infinity;
`ifdef POC_RANGE_CHECK_EN
   logic         out_of_range;
`endif

   int vectors = 0;
   int miscompares = 0;

   point_on_curve_check dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .x_in        (x_in),
      .y_in        (y_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
`ifdef POC_RANGE_CHECK_EN
      .out_of_range(out_of_range),
`endif
      .on_curve    (on_curve),
      .is_infinity (is_infinity)
   );

   always #5 clk = ~clk;

   task automatic accept(input logic [255:0] x, input logic [255:0] y);
      @(negedge clk);
      x_in = x;
      y_in = y;
      in_valid = 1'b1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL accept_in_ready got=%b want=1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x_in = ~x;
      y_in = ~y;
   endtask

   task automatic wait_out(input string name, input int lat);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 1000) begin
         @(negedge clk);
         n++;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      vectors++;
      if (!seen || n != lat) begin
         miscompares++;
         $display("FAIL %s_latency got=%0d seen=%0b want=%0d", name, n, seen, lat);
      end
   endtask

   task automatic check_res(input string name, input logic oc, input logic inf);
      vectors++;
      if (on_curve !== oc) begin
         miscompares++;
         $display("FAIL %s_on_curve got=%b want=%b", name, on_curve, oc);
      end
      vectors++;
      if (is_infinity !== inf) begin
         miscompares++;
         $display("FAIL %s_is_infinity got=%b want=%b", name, is_infinity, inf);
      end
   endtask

   task automatic release_out(input string name);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_release out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset;
      #2;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_hs in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
      check_res("reset", 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_generator;
      accept(GX, GY);
      wait_out("gen", LAT_FULL);
      check_res("gen", 1'b1, 1'b0);
      release_out("gen");
   endtask

   task automatic test_bad_point;
      accept(GX, GY1);
      wait_out("bad", LAT_FULL);
      check_res("bad", 1'b0, 1'b0);
      release_out("bad");
      accept(GX, GYN);
      wait_out("neg", LAT_FULL);
      check_res("neg", 1'b1, 1'b0);
      release_out("neg");
   endtask

   task automatic test_identity;
      accept('0, '0);
      wait_out("ident", LAT_FAST);
      check_res("ident", 1'b1, 1'b1);
      release_out("ident");
   endtask

   task automatic test_back_to_back;
      bit stable;
      accept(GX, GY);
      wait_out("bp", LAT_FULL);
      check_res("bp", 1'b1, 1'b0);
      stable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
             on_curve !== 1'b1 || is_infinity !== 1'b0) stable = 1'b0;
      end
      vectors++;
      if (!stable) begin
         miscompares++;
         $display("FAIL bp_stable got=0 want=1");
      end
      release_out("bp");
      accept(GX, GYN);
      wait_out("b2b", LAT_FULL);
      check_res("b2b", 1'b1, 1'b0);
      release_out("b2b");
   endtask

   task automatic test_reset_midop;
      accept(GX, GY);
      repeat (300) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_hs in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
      check_res("midrst", 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      accept('0, '0);
      wait_out("postrst", LAT_FAST);
      check_res("postrst", 1'b1, 1'b1);
      release_out("postrst");
   endtask

`ifdef POC_RANGE_CHECK_EN
   task automatic test_range;
      accept(P, GY);
      wait_out("range", LAT_FAST);
      check_res("range", 1'b0, 1'b0);
      vectors++;
      if (out_of_range !== 1'b1) begin
         miscompares++;
         $display("FAIL range_oor got=%b want=1", out_of_range);
      end
      release_out("range");
      accept(GX, GY);
      wait_out("inrange", LAT_FULL);
      check_res("inrange", 1'b1, 1'b0);
      vectors++;
      if (out_of_range !== 1'b0) begin
         miscompares++;
         $display("FAIL inrange_oor got=%b want=0", out_of_range);
      end
      release_out("inrange");
   endtask
`endif

   initial begin
      test_reset;
      test_generator;
      test_bad_point;
      test_identity;
      test_back_to_back;
      test_reset_midop;
`ifdef POC_RANGE_CHECK_EN
      test_range;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/point_on_curve_check.md
Name: point_on_curve_check

Overview:
- Consumer-side checker for affine points produced by the scalar multiplier.
- Accepts one point (x, y) per transaction and decides whether y^2 == x^3 + B (mod P).
- Sits between the scalar-multiplication result and any downstream key/signature logic, so invalid or corrupted results are rejected before use.
- Iterative: one bit-serial modular multiplier is reused for y*y, x*x and (x*x)*x.

Parameters:
- WIDTH, 256, coordinate and field width in bits.
- P, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F, field prime (secp256k1).
- B, 256'd7, curve constant b in y^2 = x^3 + b.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  point on x_in/y_in is valid.
- in_ready  out  1  block can accept a point (high only in IDLE).
- x_in  in  WIDTH  affine x coordinate.
- y_in  in  WIDTH  affine y coordinate.
- out_valid  out  1  result fields valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- on_curve  out  1  1 = point satisfies the curve equation or is the identity.
- is_infinity  out  1  1 = input was (0,0), the identity encoding used by the multiplier.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; in_ready=1; out_valid=0; on_curve=0; is_infinity=0; all internal registers 0. Asserting reset mid-operation aborts the check; no result is produced.
- Handshake: a transfer occurs on a rising edge with in_valid & in_ready. x_in and y_in are registered on that edge, and the block leaves IDLE.
- A result transfers on an edge with out_valid & out_ready. The block returns to IDLE on that edge.
- The input and output handshakes can never coincide, because in_ready=0 outside IDLE.
- States:
  - IDLE: wait for an accepted input.
  - CLASSIFY (1 cycle): if x==0 && y==0, set is_infinity=1 and on_curve=1, then go to DONE. Otherwise go to MUL_YY.
  - MUL_YY: yy = y*y mod P.
  - MUL_XX: xx = x*x mod P.
  - MUL_XXX: xxx = xx*x mod P.
  - FINAL (1 cycle): rhs = xxx + B mod P. on_curve = (yy == rhs). is_infinity = 0.
  - DONE: out_valid=1. Outputs are held stable until out_ready.
- Modular multiply:
  - MSB-first interleaved add-shift, exactly WIDTH cycles per multiply.
  - Each step: acc = 2*acc mod P; if multiplier bit is 1, acc = acc + a mod P.
  - Intermediates use WIDTH+1 bits. Reduction is a single conditional subtract of P per add or double, which is valid because operands are < P.
  - A bit counter runs WIDTH-1 down to 0. Wrap at 0 ends the multiply and advances the state.
- Latency is counted from the accepting edge (edge 0) to the first edge where out_valid is seen high:
  - Identity path: 2 edges.
  - Normal path: 1 (CLASSIFY) + 3*WIDTH + 1 (FINAL) + 1 = 3*WIDTH+3 = 771 edges at WIDTH=256.
- Back-pressure: out_ready low holds DONE indefinitely. Outputs must not change while out_valid=1 and out_ready=0.
- Input stability: x_in and y_in are sampled only at acceptance. Changes afterwards have no effect.

Optional Feature:
- Macro: POC_RANGE_CHECK_EN.
- Defined:
  - Adds output port out_of_range (1 bit, reset 0).
  - In CLASSIFY, if x>=P or y>=P: out_of_range=1, on_curve=0, is_infinity=0, then go to DONE. Latency is 2 edges.
  - The range test has priority over the identity test.
  - out_of_range is cleared when the next input is accepted.
- Not defined:
  - No out_of_range port and no comparison logic.
  - Inputs are assumed already reduced mod P. Behaviour for unreduced inputs is unspecified.

Test Plan:
- Generator G (x=79BE667E F9DCBBAC 55A06295 CE870B07 029BFCDB 2DCE28D9 59F2815B 16F81798, y=483ADA77 26A3C465 5DA4FBFC 0E1108A8 FD17B448 A6855419 9C47D08F FB10D4B8) -> out_valid at edge 771, on_curve=1, is_infinity=0.
- G with y incremented by 1 -> on_curve=0 at edge 771. Then G with y replaced by P-y -> on_curve=1.
- x=0, y=0 -> out_valid at edge 2, on_curve=1, is_infinity=1.
- G, out_ready held low for 100 cycles after out_valid -> outputs stable, in_ready=0. Pulse out_ready -> in_ready=1 on the next cycle. A second point accepted immediately completes correctly.
- Drop reset_n at edge 300 of a G check -> all outputs at reset values immediately (async). After release, a new (0,0) check returns is_infinity=1.
- With POC_RANGE_CHECK_EN: x=P, y=G.y -> edge 2, out_of_range=1, on_curve=0. Then G -> out_of_range=0, on_curve=1.
